// File: rtl/console_pkg.sv
// Shared constants and state encoding for the text console character writer.
package console_pkg;

    localparam logic [7:0] CC_BS  = 8'h08;
    localparam logic [7:0] CC_LF  = 8'h0A;
    localparam logic [7:0] CC_FF  = 8'h0C;
    localparam logic [7:0] CC_CR  = 8'h0D;
    localparam logic [7:0] CC_ESC = 8'h1B;

    localparam logic [7:0] PRINT_MIN = 8'h20;
    localparam logic [7:0] PRINT_MAX = 8'h7E;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ESC_X = 2'd1,
        ST_ESC_Y = 2'd2,
        ST_CLEAR = 2'd3
    } state_e;

endpackage

// File: rtl/text_console.sv
// Byte-stream console: tracks a cursor, decodes control codes and drives the
// write-only character port of the on-screen text display.
module text_console
    import console_pkg::*;
#(
    parameter int         COLS       = 32,
    parameter int         ROWS       = 28,
    parameter logic [6:0] CLEAR_CHAR = 7'h20
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic [4:0] x_wr,
    output logic [4:0] y_wr,
    output logic [6:0] char_wr,
    output logic       we,
    output logic [4:0] cur_x,
    output logic [4:0] cur_y
);

    localparam logic [4:0] XMAX = 5'(COLS - 1);
    localparam logic [4:0] YMAX = 5'(ROWS - 1);

    state_e     state_q, state_d;
    logic [4:0] cx_q, cx_d, cy_q, cy_d;
    logic [4:0] clr_x_q, clr_x_d, clr_y_q, clr_y_d;
    logic       clr_done_q, clr_done_d;
    logic       we_q, we_d;
    logic [4:0] x_wr_q, x_wr_d, y_wr_q, y_wr_d;
    logic [6:0] char_wr_q, char_wr_d;
    logic       accept;

    // Step one cell right, wrapping to the next row and back to the top (no scroll).
    function automatic logic [9:0] advance(input logic [4:0] x, input logic [4:0] y);
        logic [4:0] nx, ny;
        if (x == XMAX) begin
            nx = 5'd0;
            ny = (y == YMAX) ? 5'd0 : y + 5'd1;
        end else begin
            nx = x + 5'd1;
            ny = y;
        end
        return {nx, ny};
    endfunction

    assign cmd_ready = (state_q != ST_CLEAR);
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cx_q       <= '0;
            cy_q       <= '0;
            clr_x_q    <= '0;
            clr_y_q    <= '0;
            clr_done_q <= 1'b0;
            we_q       <= 1'b0;
            x_wr_q     <= '0;
            y_wr_q     <= '0;
            char_wr_q  <= '0;
        end else begin
            state_q    <= state_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            clr_x_q    <= clr_x_d;
            clr_y_q    <= clr_y_d;
            clr_done_q <= clr_done_d;
            we_q       <= we_d;
            x_wr_q     <= x_wr_d;
            y_wr_q     <= y_wr_d;
            char_wr_q  <= char_wr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        clr_x_d    = clr_x_q;
        clr_y_d    = clr_y_q;
        clr_done_d = clr_done_q;
        we_d       = 1'b0;
        x_wr_d     = x_wr_q;
        y_wr_d     = y_wr_q;
        char_wr_d  = char_wr_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_data >= PRINT_MIN && cmd_data <= PRINT_MAX) begin
                        we_d         = 1'b1;
                        x_wr_d       = cx_q;
                        y_wr_d       = cy_q;
                        char_wr_d    = cmd_data[6:0];
                        {cx_d, cy_d} = advance(cx_q, cy_q);
                    end else begin
                        case (cmd_data)
                            CC_CR:  cx_d = 5'd0;
                            CC_LF:  {cx_d, cy_d} = advance(XMAX, cy_q);
                            CC_BS: begin
                                if (cx_q != 5'd0) begin
                                    cx_d      = cx_q - 5'd1;
                                    we_d      = 1'b1;
                                    x_wr_d    = cx_q - 5'd1;
                                    y_wr_d    = cy_q;
                                    char_wr_d = CLEAR_CHAR;
                                end
                            end
                            CC_FF: begin
                                // Cell (0,0) is written on entry; the sweep continues from the next cell.
                                state_d            = ST_CLEAR;
                                cx_d               = 5'd0;
                                cy_d               = 5'd0;
                                we_d               = 1'b1;
                                x_wr_d             = 5'd0;
                                y_wr_d             = 5'd0;
                                char_wr_d          = CLEAR_CHAR;
                                {clr_x_d, clr_y_d} = advance(5'd0, 5'd0);
                                clr_done_d         = (COLS * ROWS == 1);
                            end
                            CC_ESC: state_d = ST_ESC_X;
                            default: ;
                        endcase
                    end
                end
            end
            ST_ESC_X: begin
                if (accept) begin
                    cx_d    = (cmd_data > {3'b000, XMAX}) ? XMAX : cmd_data[4:0];
                    state_d = ST_ESC_Y;
                end
            end
            ST_ESC_Y: begin
                if (accept) begin
                    cy_d    = (cmd_data > {3'b000, YMAX}) ? YMAX : cmd_data[4:0];
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                // One quiet cycle after the last cell keeps ready low for exactly COLS*ROWS cycles.
                if (clr_done_q) begin
                    state_d = ST_IDLE;
                end else begin
                    we_d               = 1'b1;
                    x_wr_d             = clr_x_q;
                    y_wr_d             = clr_y_q;
                    char_wr_d          = CLEAR_CHAR;
                    {clr_x_d, clr_y_d} = advance(clr_x_q, clr_y_q);
                    clr_done_d         = (clr_x_q == XMAX) && (clr_y_q == YMAX);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign we      = we_q;
    assign x_wr    = x_wr_q;
    assign y_wr    = y_wr_q;
    assign char_wr = char_wr_q;
    assign cur_x   = cx_q;
    assign cur_y   = cy_q;

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: printing, escapes, backspace, clear sweep and reset.
module tb_text_console;

    logic       clk = 1'b0;
    logic       resetn;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic [4:0] x_wr, y_wr, cur_x, cur_y;
    logic [6:0] char_wr;
    logic       we;

    int checks = 0;
    int errors = 0;

    text_console dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .x_wr      (x_wr),
        .y_wr      (y_wr),
        .char_wr   (char_wr),
        .we        (we),
        .cur_x     (cur_x),
        .cur_y     (cur_y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a byte, let one edge pass, leave outputs settled for checking.
    task automatic put(input logic [7:0] b);
        cmd_valid = 1'b1;
        cmd_data  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic [4:0] x, input logic [4:0] y, input logic [6:0] c);
        chk({tag, "_we"}, 32'(we), 32'd1);
        chk({tag, "_xy"}, {22'd0, x_wr, y_wr}, {22'd0, x, y});
        chk({tag, "_ch"}, 32'(char_wr), 32'(c));
    endtask

    task automatic chk_cur(input string tag, input logic [4:0] x, input logic [4:0] y);
        chk(tag, {22'd0, cur_x, cur_y}, {22'd0, x, y});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int nwe, nbusy, bad, lastx, lasty, ex, ey;
        resetn    = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        #12;
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_wr", {15'd0, x_wr, y_wr, char_wr}, 32'd0);
        chk_cur("rst_cur", 5'd0, 5'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rst_ready", 32'(cmd_ready), 32'd1);

        // "AB" back to back
        put(8'h41);
        chk_wr("A", 5'd0, 5'd0, 7'h41);
        chk_cur("A_cur", 5'd1, 5'd0);
        put(8'h42);
        chk_wr("B", 5'd1, 5'd0, 7'h42);
        chk_cur("B_cur", 5'd2, 5'd0);
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("AB_we_off", 32'(we), 32'd0);

        // Escape positioning and wrap at the bottom-right cell
        put(8'h1B); chk("esc_we0", 32'(we), 32'd0);
        put(8'd31); chk("esc_we1", 32'(we), 32'd0);
        put(8'd27); chk("esc_we2", 32'(we), 32'd0);
        chk_cur("esc_cur", 5'd31, 5'd27);
        put(8'h5A);
        chk_wr("Z", 5'd31, 5'd27, 7'h5A);
        chk_cur("Z_wrap", 5'd0, 5'd0);

        // Clamp, CR, LF wrap
        put(8'h1B); put(8'd40); put(8'd99);
        chk_cur("clamp", 5'd31, 5'd27);
        put(8'h0D);
        chk("cr_we", 32'(we), 32'd0);
        chk_cur("cr", 5'd0, 5'd27);
        put(8'h0A);
        chk("lf_we", 32'(we), 32'd0);
        chk_cur("lf", 5'd0, 5'd0);

        // Backspace
        put(8'h1B); put(8'd3); put(8'd5);
        put(8'h08);
        chk_wr("bs", 5'd2, 5'd5, 7'h20);
        chk_cur("bs_cur", 5'd2, 5'd5);
        put(8'h1B); put(8'd0); put(8'd5);
        put(8'h08);
        chk("bs0_we", 32'(we), 32'd0);
        chk_cur("bs0_cur", 5'd0, 5'd5);

        // Clear with the following byte held on the bus
        put(8'h0C);
        cmd_data = 8'h41;
        chk_cur("ff_cur", 5'd0, 5'd0);
        nwe = 0; nbusy = 0; bad = 0; lastx = -1; lasty = -1; ex = 0; ey = 0;
        for (int i = 0; i < 1000; i++) begin
            if (cmd_ready) break;
            nbusy++;
            if (we) begin
                if (x_wr != 5'(ex) || y_wr != 5'(ey) || char_wr != 7'h20) bad++;
                lastx = x_wr; lasty = y_wr; nwe++;
                if (ex == 31) begin ex = 0; ey = ey + 1; end else ex = ex + 1;
            end
            @(posedge clk); #1;
        end
        chk("clr_writes", 32'(nwe), 32'd896);
        chk("clr_busy", 32'(nbusy), 32'd896);
        chk("clr_order", 32'(bad), 32'd0);
        chk("clr_last", 32'(lastx * 32 + lasty), 32'(31 * 32 + 27));
        @(posedge clk); #1;
        chk_wr("held", 5'd0, 5'd0, 7'h41);
        chk_cur("held_cur", 5'd1, 5'd0);
        cmd_valid = 1'b0;

        // Reset in the middle of a clear
        put(8'h0C);
        cmd_valid = 1'b0;
        nwe = 1;
        for (int i = 0; i < 400 && nwe < 300; i++) begin
            @(posedge clk); #1;
            if (we) nwe++;
        end
        chk("mid_count", 32'(nwe), 32'd300);
        resetn = 1'b0;
        #1;
        chk("mid_we", 32'(we), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("mid_ready", 32'(cmd_ready), 32'd1);
        chk_cur("mid_cur", 5'd0, 5'd0);

        // Ignored bytes leave the cursor alone
        put(8'h1B); put(8'd4); put(8'd6);
        put(8'h07); chk("j07_we", 32'(we), 32'd0);
        put(8'h7F); chk("j7f_we", 32'(we), 32'd0);
        put(8'hC1); chk("jc1_we", 32'(we), 32'd0);
        chk_cur("junk_cur", 5'd4, 5'd6);
        cmd_valid = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
